// File: rtl/control_sequencer_pkg.sv
// Shared constants for the hardwired control unit: opcodes, T-state encoding,
// instruction classes and the per-class final T-state.
package control_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_T0     = 4'd1;
  localparam logic [3:0] S_T1     = 4'd2;
  localparam logic [3:0] S_T2     = 4'd3;
  localparam logic [3:0] S_T3     = 4'd4;
  localparam logic [3:0] S_T4     = 4'd5;
  localparam logic [3:0] S_T5     = 4'd6;
  localparam logic [3:0] S_T6     = 4'd7;
  localparam logic [3:0] S_T7     = 4'd8;
  localparam logic [3:0] S_HALTED = 4'd9;

  typedef enum logic [3:0] {
    RTYPE, IMM, UNARY, MULDIV, LD, LDI, ST, NOP, HALT
  } instr_class_e;

  // T-state on whose closing edge the instruction ends.
  function automatic logic [3:0] last_state(input instr_class_e cls);
    case (cls)
      RTYPE, IMM, LDI: last_state = S_T5;
      UNARY:           last_state = S_T4;
      MULDIV:          last_state = S_T6;
      LD, ST:          last_state = S_T7;
      default:         last_state = S_T2;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the datapath: IR/Stop in, strobes and
// debug view out. master = sequencer side, slave = datapath side.
interface control_sequencer_if #(parameter int OPW = 5);
  logic [31:0]    IR;
  logic           Stop;
  logic           PCout, Zlowout, Zhighout, MDRout, Rout, BAout, Cout;
  logic           PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, Rin, LOin, HIin;
  logic           Gra, Grb, Grc;
  logic           Read, Write;
  logic [OPW-1:0] alu_op;
  logic           Run;
  logic [3:0]     step;

  modport master (
    input  IR, Stop,
    output PCout, Zlowout, Zhighout, MDRout, Rout, BAout, Cout,
    output PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, Rin, LOin, HIin,
    output Gra, Grb, Grc, Read, Write, alu_op, Run, step
  );

  modport slave (
    output IR, Stop,
    input  PCout, Zlowout, Zhighout, MDRout, Rout, BAout, Cout,
    input  PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, Rin, LOin, HIin,
    input  Gra, Grb, Grc, Read, Write, alu_op, Run, step
  );
endinterface

// File: rtl/control_sequencer_instr_decode.sv
// Opcode to instruction-class map; anything unassigned behaves as halt.
module instr_decode
  import control_pkg::*;
(
  input  logic [4:0]   opcode_i,
  output instr_class_e cls_o
);

  always_comb begin
    cls_o = HALT;
    if (opcode_i == OP_LD)                              cls_o = LD;
    else if (opcode_i == OP_LDI)                        cls_o = LDI;
    else if (opcode_i == OP_ST)                         cls_o = ST;
    else if (opcode_i >= OP_ADD && opcode_i <= OP_SHL)  cls_o = RTYPE;
    else if (opcode_i >= OP_ADDI && opcode_i <= OP_ORI) cls_o = IMM;
    else if (opcode_i == OP_MUL || opcode_i == OP_DIV)  cls_o = MULDIV;
    else if (opcode_i == OP_NEG || opcode_i == OP_NOT)  cls_o = UNARY;
    else if (opcode_i == OP_NOP)                        cls_o = NOP;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, class-specific execute T3-T7, with
// strobes decoded combinationally from the registered T-state and IR.
module control_sequencer
  import control_pkg::*;
#(
  parameter int OPW = 5
) (
  input logic                 Clock,
  input logic                 Resetn,
  control_sequencer_if.master bus
);

  logic [3:0]     state_q, state_d;
  logic [OPW-1:0] opcode;
  instr_class_e   cls;
  logic           unused_ir;

  assign opcode    = bus.IR[31 -: OPW];
  assign unused_ir = ^bus.IR[31-OPW:0];

  instr_decode u_decode (
    .opcode_i (opcode[4:0]),
    .cls_o    (cls)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_RESET;
    else         state_q <= state_d;
  end

  // Stop only matters on the edge that closes an instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == S_T2 && cls == HALT)   state_d = S_HALTED;
        else if (state_q == last_state(cls))  state_d = bus.Stop ? S_HALTED : S_T0;
        else                                  state_d = state_q + 4'd1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RESET;
    endcase
  end

  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.MDRout = 1'b0;
    bus.Rout  = 1'b0; bus.BAout   = 1'b0; bus.Cout     = 1'b0;
    bus.PCin  = 1'b0; bus.IncPC   = 1'b0; bus.MARin    = 1'b0; bus.MDRin  = 1'b0;
    bus.IRin  = 1'b0; bus.Yin     = 1'b0; bus.Zin      = 1'b0; bus.Rin    = 1'b0;
    bus.LOin  = 1'b0; bus.HIin    = 1'b0;
    bus.Gra   = 1'b0; bus.Grb     = 1'b0; bus.Grc      = 1'b0;
    bus.Read  = 1'b0; bus.Write   = 1'b0;
    bus.alu_op = '0;
    bus.Run    = (state_q != S_RESET) && (state_q != S_HALTED);
    bus.step   = bus.Run ? state_q - 4'd1 : 4'd0;
    case (state_q)
      S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3: case (cls)
        RTYPE, IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
        UNARY:      begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_op = opcode; bus.Zin = 1'b1; end
        MULDIV:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
        LD, LDI, ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
        default: ;
      endcase
      S_T4: case (cls)
        RTYPE:      begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.alu_op = opcode; bus.Zin = 1'b1; end
        IMM:        begin bus.Cout = 1'b1; bus.alu_op = opcode; bus.Zin = 1'b1; end
        UNARY:      begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        MULDIV:     begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_op = opcode; bus.Zin = 1'b1; end
        LD, LDI, ST: begin bus.Cout = 1'b1; bus.alu_op = OPW'(OP_ADD); bus.Zin = 1'b1; end
        default: ;
      endcase
      S_T5: case (cls)
        RTYPE, IMM, LDI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        MULDIV:          begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
        LD, ST:          begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
        default: ;
      endcase
      // st drives the register onto the bus with Read low so MDR takes the bus.
      S_T6: case (cls)
        MULDIV: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
        LD:     begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
        ST:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
        default: ;
      endcase
      S_T7: case (cls)
        LD:      begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        ST:      bus.Write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule
